// File: rtl/mem_burst_responder.sv
// Memory-side cache-line burst responder backed by an internal line store.
// Serves whole-line reads and writes as in-order sequences of 32-bit beats.
module mem_burst_responder #(
    parameter int WORDS_PER_LINE = 8,
    parameter int DEPTH_LINES    = 256,
    parameter int READ_LATENCY   = 2,
    parameter int ADDR_W         = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              wvalid,
    output logic [31:0]       rdata,
    output logic              memValid,
    output logic              wready,
    output logic              busy,
    output logic              done
);

    localparam int OFF    = $clog2(WORDS_PER_LINE * 4);
    localparam int IDX_W  = $clog2(DEPTH_LINES);
    localparam int BEAT_W = $clog2(WORDS_PER_LINE);
    localparam int LAT_W  = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam int PTR_W  = IDX_W + BEAT_W;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS_PER_LINE - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  =
        LAT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        RD_LAT,
        RD_BEAT,
        WR_BEAT,
        RESP
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [BEAT_W-1:0]  beat;
    logic [LAT_W-1:0]   lat;
    logic [IDX_W-1:0]   req_idx;
    logic [PTR_W-1:0]   rd_ptr;
    logic               wr_en;
    logic               unused_addr;

    logic [31:0] store [DEPTH_LINES * WORDS_PER_LINE];

    assign req_idx     = addr[OFF+IDX_W-1:OFF];
    assign unused_addr = ^addr;
    assign wr_en       = (state == WR_BEAT) && wvalid;

    // rdata is registered, so fetch the word that will be shown after this edge
    always_comb begin
        rd_ptr = {idx, beat + 1'b1};
        if (state == IDLE)
            rd_ptr = {req_idx, {BEAT_W{1'b0}}};
        else if (state == RD_LAT)
            rd_ptr = {idx, {BEAT_W{1'b0}}};
    end

    always_ff @(posedge CLK) begin
        if (wr_en)
            store[{idx, beat}] <= wdata;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            idx      <= '0;
            beat     <= '0;
            lat      <= '0;
            rdata    <= '0;
            memValid <= 1'b0;
            wready   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (re) begin
                        idx  <= req_idx;
                        busy <= 1'b1;
                        lat  <= '0;
                        if (READ_LATENCY == 0) begin
                            state    <= RD_BEAT;
                            memValid <= 1'b1;
                            rdata    <= store[rd_ptr];
                        end else begin
                            state <= RD_LAT;
                        end
                    end else if (we) begin
                        idx    <= req_idx;
                        busy   <= 1'b1;
                        wready <= 1'b1;
                        state  <= WR_BEAT;
                    end
                end
                RD_LAT: begin
                    lat <= lat + 1'b1;
                    if (lat == LAT_LAST) begin
                        lat      <= '0;
                        state    <= RD_BEAT;
                        memValid <= 1'b1;
                        rdata    <= store[rd_ptr];
                    end
                end
                RD_BEAT: begin
                    if (beat == BEAT_LAST) begin
                        beat     <= '0;
                        memValid <= 1'b0;
                        rdata    <= '0;
                        done     <= 1'b1;
                        state    <= RESP;
                    end else begin
                        beat  <= beat + 1'b1;
                        rdata <= store[rd_ptr];
                    end
                end
                WR_BEAT: begin
                    if (wvalid) begin
                        if (beat == BEAT_LAST) begin
                            beat   <= '0;
                            wready <= 1'b0;
                            done   <= 1'b1;
                            state  <= RESP;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                RESP: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder: latency-2 instance plus a
// latency-0 instance sharing the same inputs.
module tb_mem_burst_responder;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        re, we, wvalid;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, rdata0;
    logic        memValid, wready, busy, done;
    logic        memValid0, wready0, busy0, done0;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_mem [256][8];

    always #5 CLK = ~CLK;

    mem_burst_responder #(
        .WORDS_PER_LINE(8), .DEPTH_LINES(256), .READ_LATENCY(2), .ADDR_W(32)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .re(re), .we(we), .addr(addr),
        .wdata(wdata), .wvalid(wvalid), .rdata(rdata), .memValid(memValid),
        .wready(wready), .busy(busy), .done(done)
    );

    mem_burst_responder #(
        .WORDS_PER_LINE(8), .DEPTH_LINES(256), .READ_LATENCY(0), .ADDR_W(32)
    ) dut0 (
        .CLK(CLK), .RST_N(RST_N), .re(re), .we(we), .addr(addr),
        .wdata(wdata), .wvalid(wvalid), .rdata(rdata0), .memValid(memValid0),
        .wready(wready0), .busy(busy0), .done(done0)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] base,
                            input logic [15:0] pat, input int n,
                            input string nm);
        int k = 0;
        int line = int'((a >> 5) & 32'hFF);
        we = 1'b1; addr = a;
        tick();
        we = 1'b0;
        total++;
        if (wready !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: wready=%b busy=%b need 1 1", nm, wready, busy);
        end
        for (int i = 0; i < n; i++) begin
            wvalid = pat[i];
            wdata  = base + k;
            tick();
            if (pat[i]) begin
                exp_mem[line][k] = base + k;
                k++;
            end
            if (i == n - 2) begin
                total++;
                if (done !== 1'b0) begin
                    bad++;
                    $display("FAIL %s early_done: done=%b need 0", nm, done);
                end
            end
        end
        wvalid = 1'b0;
        total++;
        if (done !== 1'b1 || wready !== 1'b0) begin
            bad++;
            $display("FAIL %s done: done=%b wready=%b need 1 0", nm, done, wready);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle: done=%b busy=%b need 0 0", nm, done, busy);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input bit junk, input string nm);
        int line = int'((a >> 5) & 32'hFF);
        re = 1'b1; addr = a;
        if (junk) begin
            we = 1'b1; wvalid = 1'b1; wdata = 32'hDEADBEEF;
        end
        tick();
        re = 1'b0;
        total++;
        if (memValid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s e0: memValid=%b busy=%b need 0 1", nm, memValid, busy);
        end
        tick();
        total++;
        if (memValid !== 1'b0) begin
            bad++;
            $display("FAIL %s e1: memValid=%b need 0", nm, memValid);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (memValid !== 1'b1 || rdata !== exp_mem[line][k]) begin
                bad++;
                $display("FAIL %s beat%0d: memValid=%b rdata=%h need 1 %h",
                         nm, k, memValid, rdata, exp_mem[line][k]);
            end
        end
        we = 1'b0; wvalid = 1'b0;
        tick();
        total++;
        if (done !== 1'b1 || memValid !== 1'b0 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL %s done: done=%b memValid=%b rdata=%h need 1 0 0",
                     nm, done, memValid, rdata);
        end
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s end: busy=%b done=%b need 0 0", nm, busy, done);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; re = 1'b0; we = 1'b0; wvalid = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) tick();
        total++;
        if ({memValid, wready, busy, done} !== 4'b0 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset: mv=%b wr=%b busy=%b done=%b rdata=%h need 0",
                     memValid, wready, busy, done, rdata);
        end
        total++;
        if ({memValid0, wready0, busy0, done0} !== 4'b0 || rdata0 !== 32'h0) begin
            bad++;
            $display("FAIL reset0: mv=%b wr=%b busy=%b done=%b rdata=%h need 0",
                     memValid0, wready0, busy0, done0, rdata0);
        end
        RST_N = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: busy=%b need 0", busy);
        end
    endtask

    task automatic test_write_read();
        do_write(32'h0000_00A0, 32'h1111_0000, 16'h00FF, 8, "wr_line5");
        do_read(32'h0000_00A0, 1'b0, "rd_line5");
    endtask

    task automatic test_write_gaps();
        do_write(32'h0000_00C0, 32'h2222_0000, 16'b111_1101_1001, 11, "wr_gaps");
        do_read(32'h0000_00C0, 1'b0, "rd_gaps");
    endtask

    task automatic test_rw_collision();
        do_read(32'h0000_00A0, 1'b1, "rd_collide");
        do_read(32'h0000_00A0, 1'b0, "rd_after_collide");
    endtask

    task automatic test_addr_wrap();
        do_write(32'h0000_2020, 32'h3333_0000, 16'h00FF, 8, "wr_wrap");
        do_read(32'h0000_0020, 1'b0, "rd_wrap");
    endtask

    task automatic test_reset_mid_read();
        re = 1'b1; addr = 32'h0000_00C0;
        tick();
        re = 1'b0;
        repeat (5) tick();
        total++;
        if (memValid !== 1'b1 || rdata !== exp_mem[6][3]) begin
            bad++;
            $display("FAIL mid_beat3: memValid=%b rdata=%h need 1 %h",
                     memValid, rdata, exp_mem[6][3]);
        end
        #2;
        RST_N = 1'b0;
        #1;
        total++;
        if ({memValid, busy, done} !== 3'b0 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: mv=%b busy=%b done=%b rdata=%h need 0",
                     memValid, busy, done, rdata);
        end
        tick();
        RST_N = 1'b1;
        tick();
        do_read(32'h0000_00C0, 1'b0, "rd_after_reset");
    endtask

    task automatic test_lat0();
        re = 1'b1; addr = 32'h0000_00A0;
        tick();
        re = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            total++;
            if (memValid0 !== 1'b1 || rdata0 !== exp_mem[5][k]) begin
                bad++;
                $display("FAIL lat0 beat%0d: memValid=%b rdata=%h need 1 %h",
                         k, memValid0, rdata0, exp_mem[5][k]);
            end
        end
        tick();
        total++;
        if (done0 !== 1'b1 || memValid0 !== 1'b0) begin
            bad++;
            $display("FAIL lat0 done: done=%b memValid=%b need 1 0", done0, memValid0);
        end
        repeat (5) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t need finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_write_gaps();
        test_rw_collision();
        test_addr_wrap();
        test_reset_mid_read();
        test_lat0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
